// File: rtl/pc_gen.sv
// Fetch program-counter generator: BOOT/RUN/HALT control with execute-stage redirects.
// Define PC_GEN_MISALIGN_TRAP_EN to divert misaligned redirect targets to TRAP_VEC and pulse misalign.
module pc_gen #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(32'h0000_0100)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic            ex_is_jal,
    input  logic            ex_is_jalr,
    input  logic            ex_cond,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic [XLEN-1:0] ex_imm,
    input  logic            halt_req,
    input  logic            resume_req,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic            flush,
    output logic            halted,
    output logic            misalign
);

`ifdef PC_GEN_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t          state;
    logic            redirect;
    logic            trap_taken;
    logic [XLEN-1:0] branch_target;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] next_pc;

    assign redirect = ex_valid & (ex_is_jal | ex_is_jalr | (ex_is_branch & ex_cond));
    assign flush    = redirect;

    always_comb begin
        branch_target = ex_pc + ex_imm;
        jalr_sum      = ex_rs1 + ex_imm;
        target        = ex_is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : branch_target;
    end

    assign trap_taken = TRAP_EN && redirect && (target[1:0] != 2'b00);

    // Redirect wins over everything; a halt request freezes pc at the address being fetched.
    always_comb begin
        next_pc = pc;
        if (redirect) begin
            next_pc = trap_taken ? TRAP_VEC : target;
        end else if ((state == RUN) && !stall && !halt_req) begin
            next_pc = pc + XLEN'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            state    <= BOOT;
            pc_valid <= 1'b0;
            halted   <= 1'b0;
            misalign <= 1'b0;
        end else begin
            pc       <= next_pc;
            misalign <= trap_taken;
            case (state)
                BOOT: begin
                    state    <= RUN;
                    pc_valid <= 1'b1;
                    halted   <= 1'b0;
                end
                RUN: begin
                    if (halt_req) begin
                        state    <= HALT;
                        pc_valid <= 1'b0;
                        halted   <= 1'b1;
                    end
                end
                HALT: begin
                    if (resume_req) begin
                        state    <= RUN;
                        pc_valid <= 1'b1;
                        halted   <= 1'b0;
                    end
                end
                default: begin
                    state    <= BOOT;
                    pc_valid <= 1'b0;
                    halted   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed, table-driven bench for pc_gen; expectations follow PC_GEN_MISALIGN_TRAP_EN.
module tb_pc_gen;

`ifdef PC_GEN_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    localparam logic [2:0] C_NONE = 3'b000;
    localparam logic [2:0] C_BR   = 3'b100;
    localparam logic [2:0] C_JAL  = 3'b010;
    localparam logic [2:0] C_JALR = 3'b001;
    localparam int NVEC = 24;

    typedef struct {
        logic        stall;
        logic        ex_valid;
        logic [2:0]  cls;
        logic        cond;
        logic [31:0] ex_pc;
        logic [31:0] rs1;
        logic [31:0] imm;
        logic        halt_req;
        logic        resume_req;
        logic        exp_flush;
        logic [31:0] exp_pc;
        logic        exp_valid;
        logic        exp_halted;
        logic        exp_mis;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        ex_valid;
    logic        ex_is_branch;
    logic        ex_is_jal;
    logic        ex_is_jalr;
    logic        ex_cond;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs1;
    logic [31:0] ex_imm;
    logic        halt_req;
    logic        resume_req;
    logic [31:0] pc;
    logic        pc_valid;
    logic        flush;
    logic        halted;
    logic        misalign;

    int checks = 0;
    int errors = 0;
    vec_t vecs [NVEC];
    vec_t idle_v;

    pc_gen dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .ex_valid     (ex_valid),
        .ex_is_branch (ex_is_branch),
        .ex_is_jal    (ex_is_jal),
        .ex_is_jalr   (ex_is_jalr),
        .ex_cond      (ex_cond),
        .ex_pc        (ex_pc),
        .ex_rs1       (ex_rs1),
        .ex_imm       (ex_imm),
        .halt_req     (halt_req),
        .resume_req   (resume_req),
        .pc           (pc),
        .pc_valid     (pc_valid),
        .flush        (flush),
        .halted       (halted),
        .misalign     (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input vec_t v);
        stall        = v.stall;
        ex_valid     = v.ex_valid;
        ex_is_branch = v.cls[2];
        ex_is_jal    = v.cls[1];
        ex_is_jalr   = v.cls[0];
        ex_cond      = v.cond;
        ex_pc        = v.ex_pc;
        ex_rs1       = v.rs1;
        ex_imm       = v.imm;
        halt_req     = v.halt_req;
        resume_req   = v.resume_req;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_v = '{0, 0, C_NONE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

        vecs[0]  = '{0, 0, C_NONE, 0, 0, 0, 0, 0, 0,                     0, 32'h8, 1, 0, 0};
        vecs[1]  = '{1, 0, C_NONE, 0, 0, 0, 0, 0, 0,                     0, 32'h8, 1, 0, 0};
        vecs[2]  = '{1, 1, C_JAL, 0, 32'h40, 0, 32'h20, 0, 0,            1, 32'h60, 1, 0, 0};
        vecs[3]  = '{0, 0, C_NONE, 0, 0, 0, 0, 0, 0,                     0, 32'h64, 1, 0, 0};
        vecs[4]  = '{0, 1, C_JALR, 0, 0, 32'h1001, 32'h4, 0, 0,          1, 32'h1004, 1, 0, 0};
        vecs[5]  = '{0, 1, C_BR, 0, 32'h100, 0, 32'hFFFF_FFF8, 0, 0,     0, 32'h1008, 1, 0, 0};
        vecs[6]  = '{0, 1, C_BR, 1, 32'h100, 0, 32'hFFFF_FFF8, 0, 0,     1, 32'hF8, 1, 0, 0};
        vecs[7]  = '{0, 0, C_JAL, 1, 32'h200, 0, 32'h10, 0, 0,           0, 32'hFC, 1, 0, 0};
        vecs[8]  = '{0, 1, C_JAL, 0, 32'h20, 0, 32'h2, 0, 0,
                     1, TRAP_EN ? 32'h100 : 32'h22, 1, 0, TRAP_EN};
        vecs[9]  = '{0, 0, C_NONE, 0, 0, 0, 0, 0, 0,
                     0, TRAP_EN ? 32'h104 : 32'h26, 1, 0, 0};
        vecs[10] = '{0, 1, C_JAL, 0, 32'h8, 0, 32'h8, 0, 0,              1, 32'h10, 1, 0, 0};
        vecs[11] = '{0, 0, C_NONE, 0, 0, 0, 0, 1, 0,                     0, 32'h10, 0, 1, 0};
        vecs[12] = '{0, 0, C_NONE, 0, 0, 0, 0, 0, 0,                     0, 32'h10, 0, 1, 0};
        vecs[13] = '{0, 0, C_NONE, 0, 0, 0, 0, 0, 1,                     0, 32'h10, 1, 0, 0};
        vecs[14] = '{0, 0, C_NONE, 0, 0, 0, 0, 0, 0,                     0, 32'h14, 1, 0, 0};
        vecs[15] = '{0, 1, C_JAL, 0, 32'h300, 0, 0, 1, 0,                1, 32'h300, 0, 1, 0};
        vecs[16] = '{0, 1, C_JAL, 0, 32'h400, 0, 32'h10, 0, 0,           1, 32'h410, 0, 1, 0};
        vecs[17] = '{1, 0, C_NONE, 0, 0, 0, 0, 0, 1,                     0, 32'h410, 1, 0, 0};
        vecs[18] = '{0, 1, C_JAL, 0, 32'hFFFF_FFF0, 0, 32'h8, 0, 0,      1, 32'hFFFF_FFF8, 1, 0, 0};
        vecs[19] = '{0, 0, C_NONE, 0, 0, 0, 0, 0, 0,                     0, 32'hFFFF_FFFC, 1, 0, 0};
        vecs[20] = '{0, 0, C_NONE, 0, 0, 0, 0, 0, 0,                     0, 32'h0, 1, 0, 0};
        vecs[21] = '{0, 0, C_NONE, 0, 0, 0, 0, 0, 1,                     0, 32'h4, 1, 0, 0};
        vecs[22] = '{0, 1, C_JALR, 0, 0, 32'h10, 32'hFFFF_FFFF, 0, 0,
                     1, TRAP_EN ? 32'h100 : 32'hE, 1, 0, TRAP_EN};
        vecs[23] = '{0, 0, C_NONE, 0, 0, 0, 0, 0, 0,
                     0, TRAP_EN ? 32'h104 : 32'h12, 1, 0, 0};

        // Reset held across edges, then the BOOT -> RUN -> first increment sequence.
        rst_n = 1'b0;
        applyStimulus(idle_v);
        tick();
        tick();
        checkOutput("reset_pc", pc, 32'h0);
        checkOutput("reset_pc_valid", {31'b0, pc_valid}, 32'h0);
        checkOutput("reset_halted", {31'b0, halted}, 32'h0);
        checkOutput("reset_misalign", {31'b0, misalign}, 32'h0);
        rst_n = 1'b1;
        #1;
        checkOutput("boot_c1_pc", pc, 32'h0);
        checkOutput("boot_c1_valid", {31'b0, pc_valid}, 32'h0);
        tick();
        checkOutput("boot_c2_pc", pc, 32'h0);
        checkOutput("boot_c2_valid", {31'b0, pc_valid}, 32'h1);
        tick();
        checkOutput("boot_c3_pc", pc, 32'h4);

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d_flush", i), {31'b0, flush}, {31'b0, vecs[i].exp_flush});
            tick();
            checkOutput($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
            checkOutput($sformatf("v%0d_valid", i), {31'b0, pc_valid}, {31'b0, vecs[i].exp_valid});
            checkOutput($sformatf("v%0d_halted", i), {31'b0, halted}, {31'b0, vecs[i].exp_halted});
            checkOutput($sformatf("v%0d_misalign", i), {31'b0, misalign}, {31'b0, vecs[i].exp_mis});
        end

        // Enter HALT, then assert reset asynchronously with a redirect pending.
        applyStimulus('{0, 0, C_NONE, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0});
        tick();
        checkOutput("pre_rst_halted", {31'b0, halted}, 32'h1);
        applyStimulus('{0, 1, C_JAL, 0, 32'h500, 0, 32'h2, 0, 0, 0, 0, 0, 0, 0});
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_pc", pc, 32'h0);
        checkOutput("async_rst_halted", {31'b0, halted}, 32'h0);
        checkOutput("async_rst_valid", {31'b0, pc_valid}, 32'h0);
        checkOutput("async_rst_misalign", {31'b0, misalign}, 32'h0);
        checkOutput("async_rst_flush", {31'b0, flush}, 32'h1);
        tick();
        checkOutput("rst_hold_pc", pc, 32'h0);
        applyStimulus(idle_v);
        rst_n = 1'b1;
        #1;
        checkOutput("rerun_c1_pc", pc, 32'h0);
        checkOutput("rerun_c1_valid", {31'b0, pc_valid}, 32'h0);
        tick();
        checkOutput("rerun_c2_pc", pc, 32'h0);
        checkOutput("rerun_c2_valid", {31'b0, pc_valid}, 32'h1);
        tick();
        checkOutput("rerun_c3_pc", pc, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning address/data width (XLEN >= 8).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-003 SHALL have parameter TRAP_VEC, default 32'h0000_0100, meaning misaligned-target trap address.
REQ-004 SHALL have ports: clk  in  1  system clock, the one clock, rising edge.
REQ-005 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: stall  in  1  hold current pc (fetch back-pressure).
REQ-007 SHALL have ports: ex_valid  in  1  execute-stage control-flow info valid.
REQ-008 SHALL have ports: ex_is_branch, ex_is_jal, ex_is_jalr  in  1 each  instruction class (one-hot or all zero).
REQ-009 SHALL have ports: ex_cond  in  1  branch condition true (ALU compare result).
REQ-010 SHALL have ports: ex_pc, ex_rs1, ex_imm  in  XLEN each  pc, rs1 value, sign-extended immediate of the execute instruction.
REQ-011 SHALL have ports: halt_req, resume_req  in  1 each  enter/leave halt.
REQ-012 SHALL have ports: pc  out  XLEN  current fetch address; pc_valid  out  1  fetch permitted; flush  out  1  younger instructions must be killed; halted  out  1  FSM in HALT; misalign  out  1  misaligned target trap pulse.

Function
REQ-013 SHALL implement states BOOT, RUN, HALT; BOOT->RUN unconditionally after one cycle; RUN->HALT on halt_req; HALT->RUN on resume_req; resume_req outside HALT ignored.
REQ-014 SHALL compute redirect = ex_valid & (ex_is_jal | ex_is_jalr | (ex_is_branch & ex_cond)), combinationally.
REQ-015 SHALL compute target: branch/jal -> ex_pc + ex_imm; jalr -> (ex_rs1 + ex_imm) with bit 0 cleared; all sums modulo 2^XLEN.
REQ-016 SHALL drive flush = redirect in the same cycle (combinational); pc loads target on the next rising edge (latency 1).
REQ-017 SHALL, in RUN without redirect and without stall, load pc + 4 (wrap modulo 2^XLEN, e.g. all-ones-minus-3 -> 0).
REQ-018 SHALL hold pc while stall=1 with no redirect; redirect overrides stall.
REQ-019 SHALL hold pc in BOOT and HALT except redirect, which still loads target; a redirect in HALT keeps state HALT.
REQ-020 SHALL, on simultaneous halt_req and redirect in RUN, load target and enter HALT.
REQ-021 SHALL drive pc_valid = 1 only in RUN; halted = 1 only in HALT.
REQ-022 SHALL treat ex_valid=0 as no redirect regardless of class/cond inputs.

Reset
REQ-023 SHALL on rst_n=0 immediately (asynchronously) set pc=RESET_PC, state=BOOT, pc_valid=0, halted=0, misalign=0; flush follows inputs combinationally.
REQ-024 SHALL, on reset asserted mid-operation (any state, pending redirect), discard it; first valid fetch after release is RESET_PC, one cycle after the first edge.

Configuration
REQ-025 SHALL, when PC_GEN_MISALIGN_TRAP_EN is defined, on redirect with target[1:0] != 0, load TRAP_VEC instead of target and pulse misalign (registered) for exactly one cycle.
REQ-026 SHALL, when PC_GEN_MISALIGN_TRAP_EN is undefined, load target unchanged and tie misalign to 0.

Verification
REQ-027 SHALL cover reset: rst_n low then released -> cycle 1 pc=0, pc_valid=0; cycle 2 pc=0, pc_valid=1; cycle 3 pc=4.
REQ-028 SHALL cover stall vs redirect: stall=1 with jal ex_pc=0x40 ex_imm=0x20 -> flush=1 same cycle, next pc=0x60.
REQ-029 SHALL cover jalr: ex_rs1=0x1001, ex_imm=0x4 -> next pc=0x1004 (bit 0 cleared), no misalign.
REQ-030 SHALL cover branch: ex_is_branch=1, ex_cond=0 -> no flush, pc+4; ex_cond=1, ex_pc=0x100, ex_imm=-8 -> pc=0xF8.
REQ-031 SHALL cover halt: halt_req at pc=0x10 -> pc holds 0x10, halted=1, pc_valid=0 until resume_req, then pc=0x14 one cycle after RUN resumes.
REQ-032 SHALL cover misalign with PC_GEN_MISALIGN_TRAP_EN: jal target 0x22 -> pc=0x100, misalign=1 for one cycle; without macro -> pc=0x22, misalign=0.
